// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: exception vector default, PC FSM state
// encoding and instruction-field widths.
package mips_pkg;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0080;
    localparam int          IMM_W          = 16;
    localparam int          JIDX_W         = 26;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } pc_state_e;

endpackage : mips_pkg

// File: rtl/pc_unit_if.sv
// Control/status bundle between the control unit and the program-counter unit.
interface pc_unit_if
    import mips_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 Stall;
    logic                 Branch;
    logic                 BranchTaken;
    logic [IMM_W-1:0]     Imm16;
    logic                 Jump;
    logic [JIDX_W-1:0]    JTarget;
    logic                 JumpReg;
    logic [WIDTH-1:0]     RegTarget;
    logic                 Exc;
    logic                 Eret;
    logic [WIDTH-1:0]     Pc;
    logic [WIDTH-1:0]     PcPlus4;
    logic [WIDTH-1:0]     Epc;
    logic                 InExc;
    logic                 Fault;
    logic [CNT_WIDTH-1:0] Retired;

    modport master (
        output Stall, Branch, BranchTaken, Imm16, Jump, JTarget,
               JumpReg, RegTarget, Exc, Eret,
        input  Pc, PcPlus4, Epc, InExc, Fault, Retired
    );

    modport slave (
        input  Stall, Branch, BranchTaken, Imm16, Jump, JTarget,
               JumpReg, RegTarget, Exc, Eret,
        output Pc, PcPlus4, Epc, InExc, Fault, Retired
    );
endinterface : pc_unit_if

// File: rtl/pc_next_sel.sv
// Combinational next-PC computation: branch/jump targets, JR alignment fault
// detection and the prioritised next-PC mux.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [WIDTH-1:0]  pc_i,
    input  logic [WIDTH-1:0]  epc_i,
    input  logic              in_exc_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic              branch_taken_i,
    input  logic [IMM_W-1:0]  imm16_i,
    input  logic              jump_i,
    input  logic [JIDX_W-1:0] jtarget_i,
    input  logic              jump_reg_i,
    input  logic [WIDTH-1:0]  reg_target_i,
    input  logic              exc_i,
    input  logic              eret_i,
    output logic [WIDTH-1:0]  pc_plus4_o,
    output logic [WIDTH-1:0]  next_pc_o,
    output logic              exc_entry_o,
    output logic              jr_fault_o,
    output logic              eret_take_o
);
    localparam logic [WIDTH-1:0] EXC_VEC_W = WIDTH'(EXC_VECTOR);
    localparam logic [WIDTH-1:0] FOUR_W    = WIDTH'(3'd4);

    logic [WIDTH-1:0] branch_tgt_s;
    logic [WIDTH-1:0] jump_tgt_s;

    assign pc_plus4_o = pc_i + FOUR_W;

    // Request qualification: a stall drops everything except an explicit Exc.
    always_comb begin
        jr_fault_o   = !stall_i && jump_reg_i && (reg_target_i[1:0] != 2'b00) && !exc_i;
        exc_entry_o  = exc_i || jr_fault_o;
        eret_take_o  = !stall_i && eret_i && in_exc_i;
        branch_tgt_s = pc_plus4_o + {{(WIDTH-IMM_W-2){imm16_i[IMM_W-1]}}, imm16_i, 2'b00};
        jump_tgt_s   = {pc_plus4_o[WIDTH-1:28], jtarget_i, 2'b00};
    end

    // Next-PC priority mux.
    always_comb begin
        next_pc_o = pc_plus4_o;
        if (exc_entry_o) begin
            next_pc_o = EXC_VEC_W;
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end else if (eret_take_o) begin
            next_pc_o = epc_i;
        end else if (jump_reg_i) begin
            next_pc_o = reg_target_i;
        end else if (jump_i) begin
            next_pc_o = jump_tgt_s;
        end else if (branch_i && branch_taken_i) begin
            next_pc_o = branch_tgt_s;
        end else begin
            next_pc_o = pc_plus4_o;
        end
    end
endmodule : pc_next_sel

// File: rtl/pc_unit.sv
// Program-counter unit: PC/EPC registers, RUN/EXC handler FSM, JR fault pulse
// and retired-instruction counter.
module pc_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [31:0]      EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int               CNT_WIDTH    = 32
) (
    input  logic      Clk,
    input  logic      Rst_n,
    pc_unit_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);

    pc_state_e            state_q, state_d;
    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [WIDTH-1:0]     epc_q, epc_d;
    logic                 fault_q, fault_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic [WIDTH-1:0]     pc_plus4_s;
    logic                 exc_entry_s;
    logic                 jr_fault_s;
    logic                 eret_take_s;

    pc_next_sel #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .pc_i           (pc_q),
        .epc_i          (epc_q),
        .in_exc_i       (state_q == ST_EXC),
        .stall_i        (bus.Stall),
        .branch_i       (bus.Branch),
        .branch_taken_i (bus.BranchTaken),
        .imm16_i        (bus.Imm16),
        .jump_i         (bus.Jump),
        .jtarget_i      (bus.JTarget),
        .jump_reg_i     (bus.JumpReg),
        .reg_target_i   (bus.RegTarget),
        .exc_i          (bus.Exc),
        .eret_i         (bus.Eret),
        .pc_plus4_o     (pc_plus4_s),
        .next_pc_o      (pc_d),
        .exc_entry_o    (exc_entry_s),
        .jr_fault_o     (jr_fault_s),
        .eret_take_o    (eret_take_s)
    );

    // State, EPC capture, fault pulse and retirement count next-state logic.
    always_comb begin
        state_d   = state_q;
        epc_d     = epc_q;
        fault_d   = jr_fault_s;
        retired_d = retired_q;
        case (state_q)
            ST_RUN: begin
                if (exc_entry_s) begin
                    state_d = ST_EXC;
                    epc_d   = pc_q;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_EXC: begin
                if (exc_entry_s) begin
                    state_d = ST_EXC;
                end else if (eret_take_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_EXC;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (!bus.Stall && !exc_entry_s) begin
            retired_d = retired_q + CNT_ONE;
        end else begin
            retired_d = retired_q;
        end
    end

    // Architectural registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_VECTOR;
            epc_q     <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    assign bus.Pc      = pc_q;
    assign bus.PcPlus4 = pc_plus4_s;
    assign bus.Epc     = epc_q;
    assign bus.InExc   = (state_q == ST_EXC);
    assign bus.Fault   = fault_q;
    assign bus.Retired = retired_q;
endmodule : pc_unit

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit: the successor of the plain PC register in the MIPS monocycle datapath. It owns the PC register and the next-PC selection (sequential, branch, jump, jump-register), plus stall, exception entry/return with an EPC register, misaligned jump-register fault detection and a retired-instruction counter. It sits at the front of the datapath, feeds instruction memory, and takes control signals from the control unit and ALU zero/compare logic.

## Interface
- WIDTH, 32: PC/data width; legal values 32 or 64.
- RESET_VECTOR, 0: PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080: handler entry address, zero-extended to WIDTH.
- CNT_WIDTH, 32: retired-instruction counter width.

- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Stall  in  1  hold PC and counter this cycle.
- Branch  in  1  current instruction is a conditional branch.
- BranchTaken  in  1  branch condition true; ignored unless Branch.
- Imm16  in  16  branch offset in words.
- Jump  in  1  J/JAL.
- JTarget  in  26  jump index field.
- JumpReg  in  1  JR/JALR.
- RegTarget  in  WIDTH  JR target register value.
- Exc  in  1  exception request from datapath.
- Eret  in  1  return from exception.
- Pc  out  WIDTH  current PC (registered).
- PcPlus4  out  WIDTH  Pc + 4 (combinational).
- Epc  out  WIDTH  saved exception PC (registered).
- InExc  out  1  handler mode (registered).
- Fault  out  1  one-cycle pulse: misaligned JR detected in previous cycle.
- Retired  out  CNT_WIDTH  count of non-stalled cycles.

## Operation
- States: RUN (InExc=0), EXC (InExc=1).
- Next-PC priority, highest first: Exc or JR fault; Eret (EXC only); JumpReg; Jump; Branch&&BranchTaken; PcPlus4.
- Branch target: PcPlus4 + (sign-extend(Imm16) << 2), modulo 2^WIDTH.
- Jump target: {PcPlus4[WIDTH-1:28], JTarget, 2'b00}.
- JR fault: JumpReg with RegTarget[1:0] != 0 and no Exc. PC is not loaded with RegTarget; handled exactly as Exc, and Fault pulses next cycle.
- Exception entry (Exc or fault), RUN: Pc <= EXC_VECTOR, Epc <= current Pc, state -> EXC.
- Exception in EXC: Pc <= EXC_VECTOR, Epc unchanged, stays EXC.
- Eret in EXC: Pc <= Epc, state -> RUN. Eret in RUN: ignored, normal selection applies.
- Stall: Pc, Epc, state, Retired hold; all other requests dropped. Exc overrides Stall.
- Retired increments by 1 on every edge where Stall=0 and no exception entry; wraps at 2^CNT_WIDTH.

## Timing
- Reset (Rst_n low, async): Pc=RESET_VECTOR, Epc=0, InExc=0, Fault=0, Retired=0. Release is sampled on the next rising edge.
- All state updates on rising Clk. The selected next PC is visible on Pc one cycle after the request.
- PcPlus4 follows Pc combinationally, zero latency.
- Fault asserts the cycle after the offending JR, for exactly one cycle.
- Reset asserted mid-handler: return to RUN at RESET_VECTOR; Epc cleared.

## Structure
- Shared package mips_pkg: EXC_VECTOR default, state enum encoding (RUN=0, EXC=1), and the instruction-field widths (16 and 26).
- One sub-module: pc_next_sel, purely combinational target computation and priority mux. The pc_unit top holds the registers, FSM and counter.

## Test plan
- Reset, then 3 free-running cycles with no requests -> Pc 0,4,8,12; Retired=3.
- Pc=0x100, Branch=1, BranchTaken=1, Imm16=0xFFFE -> next Pc=0xFC. BranchTaken=0 -> next Pc=0x104.
- Pc=0x1000_0010, Jump, JTarget=0x40 -> next Pc=0x1000_0100. JumpReg, RegTarget=0x200 -> next Pc=0x200.
- Pc=0x40, JumpReg, RegTarget=0x202 -> next Pc=0x80, Epc=0x40, InExc=1, Fault pulse one cycle. Eret -> Pc=0x40, InExc=0.
- Stall=1 for 2 cycles with Jump asserted -> Pc and Retired unchanged. Exc during Stall -> Pc=0x80.
- Exc at Pc=0x20, then Exc again in handler -> Epc stays 0x20. Rst_n low mid-cycle -> Pc=0 immediately, InExc=0.
